// File: rtl/id_ex_if.sv
// id_ex_if: ID/EX beat bus (valid/ready handshake plus decode payload)
interface id_ex_if #(
   parameter int XLEN    = 32,
   parameter int RN_W    = 4,
   parameter int ALUOP_W = 2
);
   logic               valid;
   logic               ready;
   logic [XLEN-1:0]    pc;
   logic [XLEN-1:0]    rd1;
   logic [XLEN-1:0]    rd2;
   logic [XLEN-1:0]    imm;
   logic [RN_W-1:0]    rn1;
   logic [RN_W-1:0]    rn2;
   logic [RN_W-1:0]    wn;
   logic [ALUOP_W-1:0] aluop;
   logic [4:0]         ctrl;
   modport master (output valid, pc, rd1, rd2, imm, rn1, rn2, wn, aluop, ctrl, input ready);
   modport slave (input valid, pc, rd1, rd2, imm, rn1, rn2, wn, aluop, ctrl, output ready);
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX stage register with valid/ready, optional skid entry, flush and stall counter
module id_ex_pipe_reg #(
   parameter int XLEN    = 32,
   parameter int RN_W    = 4,
   parameter int ALUOP_W = 2,
   parameter int SKID    = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   id_ex_if.slave           in_bus,
   id_ex_if.master          out_bus,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int PW = 4*XLEN + 3*RN_W + ALUOP_W + 5;
   logic [PW-1:0]    in_pl, main_q, main_d, skid_q, skid_d;
   logic             main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q;
   logic             in_fire, out_fire, main_ld;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [4:0]       ctrl;
   assign in_pl = {in_bus.pc, in_bus.rd1, in_bus.rd2, in_bus.imm, in_bus.rn1, in_bus.rn2,
                   in_bus.wn, in_bus.aluop, in_bus.ctrl};
   assign in_bus.ready = (SKID != 0) ? rdy_q : (!main_v_q | out_bus.ready);
   assign in_fire = in_bus.valid & in_bus.ready;
   assign out_fire = main_v_q & out_bus.ready;
   assign main_ld = !main_v_q | out_fire;
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      main_v_d = main_v_q;
      skid_v_d = 1'b0;
      if (SKID != 0) begin
         // the skid entry is older than any incoming beat, so it drains first
         main_v_d = main_ld ? (skid_v_q | in_fire) : 1'b1;
         main_d = !main_ld ? main_q : skid_v_q ? skid_q : in_fire ? in_pl : main_q;
         skid_v_d = skid_v_q ? !main_ld : (!main_ld & in_fire);
         skid_d = (!skid_v_q & !main_ld & in_fire) ? in_pl : skid_q;
      end else begin
         main_v_d = in_fire | (main_v_q & !out_fire);
         main_d = in_fire ? in_pl : main_q;
      end
      main_v_d = main_v_d & !flush;
      skid_v_d = skid_v_d & !flush;
      stall_d = (main_v_q & !out_bus.ready & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         rdy_q <= 1'b1;
         stall_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         rdy_q <= !skid_v_d;
         stall_q <= stall_d;
      end
   end
   assign {out_bus.pc, out_bus.rd1, out_bus.rd2, out_bus.imm, out_bus.rn1, out_bus.rn2,
           out_bus.wn, out_bus.aluop, ctrl} = main_q;
   // bubbles must never carry write/memory enables downstream
   assign out_bus.ctrl = ctrl & {5{main_v_q}};
   assign out_bus.valid = main_v_q;
   assign stall_cnt = stall_q;
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline stage register with a valid/ready handshake, an optional skid buffer, flush support and a stall counter. It sits between decode and execute and carries the PC, operands, immediate, register numbers, ALU op and control bits. It preserves full throughput under backpressure and inserts safe bubbles on flush. It replaces the free-running ID/EX register in backpressured or flushing pipelines.

Parameters:
XLEN, 32, width of pc, rd1, rd2 and imm fields
RN_W, 4, register-number width
ALUOP_W, 2, ALU opcode width
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode beat valid
in_ready  out  1  stage can accept a beat
in_pc, in_rd1, in_rd2, in_imm  in  XLEN each  decode payload
in_rn1, in_rn2, in_wn  in  RN_W each  source and destination register numbers
in_aluop  in  ALUOP_W  ALU opcode
in_ctrl  in  5  {EnRW, MReg, MW, MR, ALUSrc}
flush  in  1  kill all held and incoming beats
out_valid  out  1  execute beat valid
out_ready  in  1  execute accepts beat
out_pc, out_rd1, out_rd2, out_imm  out  XLEN each  payload to execute
out_rn1, out_rn2, out_wn  out  RN_W each  register numbers to execute
out_aluop  out  ALUOP_W  ALU opcode to execute
out_ctrl  out  5  control bits; forced to 0 when out_valid=0
stall_cnt  out  CNT_W  saturating count of backpressure cycles

Behaviour:
- Clock is clk. reset is synchronous and active-high.
- Reset values: out_valid=0, all payload outputs 0, out_ctrl=0, stall_cnt=0, skid entry empty. in_ready=1 in the cycle after reset.
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload must not be sampled without the matching fire.
- Latency: 1 cycle. A beat accepted at edge N appears at out_* after edge N when the main entry is empty or firing.
- Throughput: 1 beat per cycle with out_ready held high.
- Order: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- SKID=1:
  - in_ready = !skid_valid, driven from a flop.
  - Main update: if main is empty or out_fire, main loads the skid entry when skid_valid, otherwise the input when in_fire. If neither is available, main becomes empty.
  - Skid capture: if main is full, out_fire=0 and in_fire=1, the beat goes into skid. in_ready drops the next cycle.
  - Skid empties when main loads from it.
  - Simultaneous out_fire and in_fire with skid full cannot occur, because in_ready=0.
- SKID=0:
  - No skid storage.
  - in_ready = !out_valid | out_ready, combinational.
  - Main loads on in_fire.
- Hold under backpressure: while out_valid=1 and out_ready=0, every out_* field is held stable.
- Flush:
  - At the next edge, main and skid become invalid and a beat accepted in the flush cycle is discarded.
  - in_ready is not gated by flush.
  - An out_fire in the flush cycle still completes; downstream consumed it.
  - After flush: out_valid=0 and out_ctrl=0. Payload fields hold their last values and are don't-care.
- Bubble safety: out_ctrl is the registered ctrl ANDed with out_valid. EnRW, MW and MR are therefore never asserted on a bubble.
- Stall counter:
  - Increments by 1 at each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
  - Flush does not affect it.
- Reset mid-operation: reset overrides flush and all handshakes. Held beats are lost.

Test Plan:
1. Assert reset for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_pc=0, stall_cnt=0; in_ready=1 one cycle after reset falls.
2. One beat with pc=0x100, rd1=5, rd2=7, imm=0xFFFFFFFC, wn=3, aluop=2, ctrl=0x1F, out_ready=1 -> next cycle out_valid=1 with identical fields; following cycle out_valid=0, out_ctrl=0.
3. Four back-to-back beats with pc=0x0,0x4,0x8,0xC and out_ready=1 -> four consecutive out beats in order with no gap.
4. SKID=1: accept beats A (pc=0x10) and B (pc=0x14) while out_ready=0 for 3 cycles -> out_pc=0x10 held, in_ready=0 after B, stall_cnt=3. Then out_ready=1 -> A then B on consecutive cycles, and in_ready returns to 1.
5. Main and skid both full, flush=1 together with in_valid=1 (pc=0x20) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; pc=0x20 never appears at the output.
6. SKID=0, CNT_W=4: in_ready tracks out_ready in the same cycle while full. Hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated).
